// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
// Purpose: FSM state encodings, port owner codes, load/store funct3 codes and a
//          saturating counter helper shared by mem_port_arbiter and mem_arb_grant.
// Ports:   none (package).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_grant.sv
// rtl/mem_port_arbiter_grant.sv - fetch/data priority decision with IF starvation guard
// Purpose: picks the next owner when the arbiter is able to grant. D wins by default;
//          IF is forced ahead once it has lost STARVE_LIMIT consecutive decisions to D.
// Ports:   clk, rst          clock, async active-high reset
//          if_req, d_req     pending requests
//          decide            high in the cycles where a grant may be issued (IDLE/RESP)
//          grant_if, grant_d one-hot grant (both low when decide=0 or no request)
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic decide,
  output logic grant_if,
  output logic grant_d
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             if_forced;

  assign if_forced = if_req && (starve_cnt_q == LIMIT_V);
  assign grant_d   = decide && d_req && !if_forced;
  assign grant_if  = decide && if_req && !grant_d;

  // Counts D wins only while IF is actually waiting; any gap in if_req forgives the history.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_d && (starve_cnt_q != LIMIT_V)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port unified memory arbiter for IF and MEM-stage requesters
// Purpose: sequences each access as grant -> ACCESS -> RESP, drives the memory pins from the
//          owning port during ACCESS only, registers read data and pulses a one-cycle ack.
// Optional: ARB_STATS_EN adds saturating grant/wait statistics outputs.
// Ports:   clk, rst                         clock, async active-high reset
//          if_req/if_addr -> if_ack/if_rdata fetch port (word fetch)
//          d_req/d_we/d_re/d_funct3/d_addr/d_wdata -> d_ack/d_rdata  load/store port
//          mem_read/mem_write/mem_funct3/mem_addr/mem_wdata, mem_rdata  memory pins
//          stat_if_grants/stat_d_grants/stat_if_wait  (ARB_STATS_EN only)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_re,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_if_grants,
  output logic [15:0]       stat_d_grants,
  output logic [15:0]       stat_if_wait
`endif
);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        decide;
  logic        grant_if;
  logic        grant_d;
  logic        in_access;

  assign decide    = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign in_access = (state_q == ST_ACCESS);

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .d_req   (d_req),
    .decide  (decide),
    .grant_if(grant_if),
    .grant_d (grant_d)
  );

  // State register. Async reset also drops mem_write immediately since pins decode state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Next state and owner latch.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = (if_req || d_req) ? ST_ACCESS : ST_IDLE;
      end
      ST_ACCESS: state_d = ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
    if (grant_d) begin
      owner_d = OWN_D;
    end else if (grant_if) begin
      owner_d = OWN_IF;
    end
  end

  // Memory pins from the owner during ACCESS; response capture at the ACCESS->RESP edge.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = 3'b000;
    mem_addr   = '0;
    mem_wdata  = '0;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (in_access) begin
      if (owner_q == OWN_D) begin
        mem_addr   = d_addr;
        mem_funct3 = d_funct3;
        d_ack_d    = 1'b1;
        if (d_we) begin
          mem_write = 1'b1;
          mem_wdata = d_wdata;
          d_rdata_d = '0;
        end else begin
          mem_read  = d_re;
          d_rdata_d = mem_rdata;
        end
      end else begin
        // Fetch relies on the memory's unqualified full-word read path.
        mem_addr   = if_addr;
        mem_funct3 = F3_LW;
        if_ack_d   = 1'b1;
        if_rdata_d = mem_rdata;
      end
    end
  end

  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_if_grants_q, stat_if_grants_d;
  logic [15:0] stat_d_grants_q, stat_d_grants_d;
  logic [15:0] stat_if_wait_q, stat_if_wait_d;

  always_comb begin
    stat_if_grants_d = grant_if ? sat_inc16(stat_if_grants_q) : stat_if_grants_q;
    stat_d_grants_d  = grant_d ? sat_inc16(stat_d_grants_q) : stat_d_grants_q;
    stat_if_wait_d   = (if_req && !if_ack_q) ? sat_inc16(stat_if_wait_q) : stat_if_wait_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_if_grants_q <= '0;
      stat_d_grants_q  <= '0;
      stat_if_wait_q   <= '0;
    end else begin
      stat_if_grants_q <= stat_if_grants_d;
      stat_d_grants_q  <= stat_d_grants_d;
      stat_if_wait_q   <= stat_if_wait_d;
    end
  end

  assign stat_if_grants = stat_if_grants_q;
  assign stat_d_grants  = stat_d_grants_q;
  assign stat_if_wait   = stat_if_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic        d_re;
  logic [2:0]  d_funct3;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef ARB_STATS_EN
  logic [15:0] stat_if_grants;
  logic [15:0] stat_d_grants;
  logic [15:0] stat_if_wait;
`endif

  mem_port_arbiter #(.ADDR_W(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_re(d_re), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_if_grants(stat_if_grants), .stat_d_grants(stat_d_grants), .stat_if_wait(stat_if_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-addressed memory model: little-endian, lanes wrap modulo 256.
  logic [7:0] mem [256];

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {mem[a3], mem[a2], mem[a1], mem[a]};
  endfunction

  always_comb begin
    logic [31:0] w;
    w = mem_word(mem_addr);
    mem_rdata = w;
    if (mem_read) begin
      case (mem_funct3)
        F3_LB:   mem_rdata = {{24{w[7]}}, w[7:0]};
        F3_LH:   mem_rdata = {{16{w[15]}}, w[15:0]};
        F3_LBU:  mem_rdata = {24'd0, w[7:0]};
        F3_LHU:  mem_rdata = {16'd0, w[15:0]};
        default: mem_rdata = w;
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] = mem_wdata[7:0];
      if (mem_funct3 != F3_SB) mem[mem_addr + 8'd1] = mem_wdata[15:8];
      if (mem_funct3 == F3_SW) begin
        mem[mem_addr + 8'd2] = mem_wdata[23:16];
        mem[mem_addr + 8'd3] = mem_wdata[31:24];
      end
    end
  end

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  bit hold_reqs = 0;
  int run_len = 0;
  int max_if_wait = 0;
  int tb_if_grants = 0;
  int tb_d_grants = 0;
  int tb_if_wait = 0;

  always @(posedge clk) begin
    if (rst) tb_if_wait <= 0;
    else if (if_req && !if_ack && tb_if_wait < 65535) tb_if_wait <= tb_if_wait + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    sb.push_back(e);
  endtask

  // Waits for the next ack, pops the scoreboard and compares port, data and latency.
  task automatic expect_ack(input string tag, input int max_cyc, input int exp_lat);
    int n;
    bit got;
    exp_t e;
    n = 0;
    got = 0;
    while (!got && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
      if (if_req && !if_ack) run_len++;
      else run_len = 0;
      if (run_len > max_if_wait) max_if_wait = run_len;
      if (if_ack || d_ack) begin
        got = 1;
        if (sb.size() == 0) begin
          check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({tag, "_port"}, {30'd0, if_ack, d_ack}, e.is_d ? 32'd1 : 32'd2);
          check({tag, "_data"}, d_ack ? d_rdata : if_rdata, e.data);
          if (exp_lat > 0) check({tag, "_lat"}, n, exp_lat);
        end
        if (if_ack) tb_if_grants++;
        if (d_ack) tb_d_grants++;
        if (!hold_reqs) begin
          if (d_ack) d_req = 1'b0;
          if (if_ack) if_req = 1'b0;
        end
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=no_ack expected=ack_within_%0d", tag, max_cyc);
    end
  endtask

  task automatic d_op(input string tag, input logic we, input logic [2:0] f3,
                      input logic [7:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
    push(1'b1, exp_rd);
    d_req = 1'b1;
    d_we = we;
    d_re = !we;
    d_funct3 = f3;
    d_addr = a;
    d_wdata = wd;
    expect_ack(tag, 6, 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[3], mem[2], mem[1], mem[0]} = 32'h12345097;
    {mem[7], mem[6], mem[5], mem[4]} = 32'h00A00093;
    {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'h11223344;
    mem[8'hFE] = 8'hAA;
    mem[8'hFF] = 8'hBB;

    rst = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_re = 0;
    d_funct3 = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_mem_ctl", {29'd0, mem_read, mem_write, (mem_addr != 0)}, 32'd0);

    // Fetch from IDLE: ACCESS drives address with mem_read low, ack 2 cycles after request.
    push(1'b0, 32'h12345097);
    if_addr = 8'h00;
    if_req = 1'b1;
    @(posedge clk);
    #1;
    check("if_access_pins", {22'd0, mem_read, mem_write, mem_addr}, 32'd0);
    expect_ack("if_fetch0", 4, 1);

    // Store then loads of several widths.
    d_op("sw_c8", 1'b1, F3_SW, 8'hC8, 32'hDEADBEEF, 32'd0);
    check("sw_c8_mem", mem_word(8'hC8), 32'hDEADBEEF);
    d_op("lw_c8", 1'b0, F3_LW, 8'hC8, 32'd0, 32'hDEADBEEF);
    d_op("lb_cb", 1'b0, F3_LB, 8'hCB, 32'd0, 32'hFFFFFFDE);
    d_op("lbu_cb", 1'b0, F3_LBU, 8'hCB, 32'd0, 32'h000000DE);
    d_op("lh_c8", 1'b0, F3_LH, 8'hC8, 32'd0, 32'hFFFFBEEF);
    d_op("lhu_c8", 1'b0, F3_LHU, 8'hC8, 32'd0, 32'h0000BEEF);

    // Simultaneous requests in IDLE: D first, IF acked two cycles later.
    push(1'b1, 32'hDEADBEEF);
    push(1'b0, 32'h12345097);
    d_req = 1'b1; d_we = 1'b0; d_re = 1'b1; d_funct3 = F3_LW; d_addr = 8'hC8;
    if_req = 1'b1; if_addr = 8'h00;
    expect_ack("simul_d", 6, 2);
    expect_ack("simul_if", 6, 2);
    check("simul_d_rdata_kept", d_rdata, 32'hDEADBEEF);

    // Both requests held: D x4 then IF, one access every two cycles.
    for (int i = 0; i < 20; i++) push(i % 5 != 4, (i % 5 == 4) ? 32'h12345097 : 32'hDEADBEEF);
    hold_reqs = 1;
    max_if_wait = 0;
    run_len = 0;
    d_req = 1'b1;
    if_req = 1'b1;
    total = 0;
    for (int i = 0; i < 20; i++) begin
      int t0;
      t0 = $time;
      expect_ack($sformatf("cont%0d", i), 4, 0);
      total += (int'($time) - t0) / 10;
    end
    hold_reqs = 0;
    d_req = 1'b0;
    if_req = 1'b0;
    check("cont_cycles", total, 32'd40);
    check("cont_if_wait_le10", (max_if_wait <= 10) ? 32'd1 : 32'd0, 32'd1);

    // Reset in the middle of a store: no write, acks cleared, arbiter idle.
    d_req = 1'b1; d_we = 1'b1; d_re = 1'b0; d_funct3 = F3_SW; d_addr = 8'h10; d_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check("rst_mid_write_before", {31'd0, mem_write}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_write_drop", {31'd0, mem_write}, 32'd0);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    d_we = 1'b0;
    rst = 1'b0;
    tb_if_grants = 0;
    tb_d_grants = 0;
    check("rst_mid_mem", mem_word(8'h10), 32'h11223344);
    check("rst_mid_d_rdata", d_rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_mid_idle%0d", i), {28'd0, if_ack, d_ack, mem_read, mem_write}, 32'd0);
    end

    // Address wrap across the top of memory, then a fetch.
    d_op("lw_fe_wrap", 1'b0, F3_LW, 8'hFE, 32'd0, 32'h5097BBAA);
    push(1'b0, 32'h00A00093);
    if_addr = 8'h04;
    if_req = 1'b1;
    expect_ack("if_fetch4", 6, 2);
    check("if_fetch4_d_kept", d_rdata, 32'h5097BBAA);

`ifdef ARB_STATS_EN
    check("stat_if_grants", {16'd0, stat_if_grants}, tb_if_grants);
    check("stat_d_grants", {16'd0, stat_d_grants}, tb_d_grants);
    check("stat_if_wait", {16'd0, stat_if_wait}, tb_if_wait);
`endif
    check("sb_drained", sb.size(), 32'd0);

    $display("model grants if=%0d d=%0d if_wait=%0d", tb_if_grants, tb_d_grants, tb_if_wait);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
